traffic_intersection_ctrl: RTL and testbench
============================================

// Module: traffic_intersection_ctrl
// PURPOSE
//  N-phase intersection controller: parametrised successor of the single-head light FSM.
//  Rotates right-of-way through NUM_PHASES approaches (ALLRED -> GREEN -> YELLOW per phase),
//  latches pedestrian requests and grants walk with extended green.
//  Sits between the board tick/clock domain and per-approach lamp drivers.
// PARAMETERS
//  NUM_PHASES  4   approaches served in rotation (2..8)
//  TIMER_W     8   dwell timer width; every *_CYC must be in 1..2**TIMER_W
//  GREEN_CYC   6   green dwell, cycles
//  YELLOW_CYC  2   yellow dwell, cycles
//  ALLRED_CYC  1   all-red clearance between phases, cycles
//  PED_CYC     10  green dwell when walk granted (effective = max(GREEN_CYC, PED_CYC))
//  FLASH_CYC   4   half-period of night flash (macro build only)
// PORTS
//  clk         in   1            single clock; all state on rising edge
//  rst         in   1            asynchronous, active-high reset
//  enable      in   1            1 = advance timer/FSM; 0 = freeze everything
//  ped_req     in   NUM_PHASES   pedestrian button per phase, level or pulse
//  night_mode  in   1            present only when TLC_NIGHT_FLASH_EN is defined
//  red         out  NUM_PHASES   per-phase red lamp
//  yellow      out  NUM_PHASES   per-phase yellow lamp
//  green       out  NUM_PHASES   per-phase green lamp
//  ped_walk    out  NUM_PHASES   per-phase walk lamp
//  phase_idx   out  $clog2(NUM_PHASES)  current phase
//  state       out  3            FSM state encoding (tlc_pkg)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-phase): state=ALLRED, phase_idx=0, red=all 1s,
//    yellow/green/ped_walk=0, ped pending=0, timer=ALLRED_CYC-1.
//  - All outputs registered, updated on the same edge as state; no comb paths in->out.
//  - Timer loads D-1 on state entry, decrements while enable=1; exit when timer==0 & enable:
//    each state lasts exactly D enabled cycles.
//  - Sequence: ALLRED(k) -> GREEN(k) -> YELLOW(k) -> ALLRED((k+1) mod NUM_PHASES); phase_idx
//    increments on YELLOW->ALLRED edge, wraps NUM_PHASES-1 -> 0.
//  - Lamps: phase k in GREEN: green[k]=1; in YELLOW: yellow[k]=1; every other phase, and all
//    phases in ALLRED, red=1. Invariant: at most one phase non-red; exactly one lamp per phase.
//  - ped_req[p] sets sticky pend[p] any cycle (also while enable=0).
//  - GREEN(p) entry: walk=pend[p]|ped_req[p]; pend[p] cleared; if walk, dwell=max(GREEN,PED),
//    ped_walk[p]=1 whole GREEN, 0 from YELLOW on. Req arriving during GREEN(p) after entry
//    re-sets pend[p] -> served next rotation.
//  - enable=0: timer, state, phase_idx, lamps hold; pend still captures requests.
//  - Illegal state: next edge -> ALLRED, phase 0, full clearance.
// CONFIGURATION
//  TLC_NIGHT_FLASH_EN defined: night_mode port and state FLASH exist. night_mode sampled at
//   ALLRED exit: if 1 go FLASH (red=0, green=0, ped_walk=0, all yellow toggle every FLASH_CYC
//   enabled cycles, starting on). In FLASH, night_mode=0 at half-period end -> ALLRED,
//   phase 0, full ALLRED_CYC. pend kept.
//  Undefined: no night_mode port, FLASH unreachable/absent, behaviour as above only.
// STRUCTURE
//  tlc_pkg: state enum (ALLRED=0, GREEN=1, YELLOW=2, FLASH=3), lamp-one-hot helpers,
//   parameter range checks.
//  Sub-module tlc_dwell_timer: TIMER_W down-counter with load/enable/zero flag.
//  Top holds FSM, phase counter, pend register, output registers.
// TESTING
//  1 defaults, enable=1, no ped: red=1111 1 cyc, green[0] 6, yellow[0] 2, allred 1, green[1]...;
//    phase 0 green recurs every 36 cycles.
//  2 1-cycle ped_req[2] during GREEN(0) -> GREEN(2) lasts 10 cyc with ped_walk[2]=1;
//    next rotation GREEN(2)=6, no walk.
//  3 enable=0 for 5 cyc at 3rd cycle of GREEN(1) -> outputs frozen; green[1] total 11 wall cyc.
//  4 rst pulse mid-YELLOW(3) with pend[1]=1 -> same cycle red=1111, phase_idx=0, pend cleared.
//  5 ped_req[0] held during GREEN(0) after entry -> no walk now; walk granted next GREEN(0).
//  6 (macro) night_mode=1 -> after ALLRED, yellow=1111 4 cyc / 0000 4 cyc, red=0; drop -> ALLRED,
//    then GREEN(0).

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-phase intersection controller.
// State encoding is visible on the o_state port, so keep the values stable.
package tlc_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        FLASH  = 3'd3
    } tlc_state_e;

    // Lamp-select helper: is lamp position p owned by phase idx.
    function automatic logic lamp_sel(input int idx, input int p);
        return (idx == p);
    endfunction

    // A dwell of d cycles is loaded as d-1, so d must be in 1..2**tw.
    function automatic bit dwell_ok(input int d, input int tw);
        return (d >= 1) && (longint'(d) <= (longint'(1) << tw));
    endfunction

    // Legal parameter combination for the controller.
    function automatic bit tlc_params_ok(input int np, input int tw, input int g,
                                         input int y, input int ar, input int pd,
                                         input int fl);
        return (np >= 2) && (np <= 8) && (tw >= 1) && (tw <= 31) &&
               dwell_ok(g, tw) && dwell_ok(y, tw) && dwell_ok(ar, tw) &&
               dwell_ok(pd, tw) && dwell_ok(fl, tw);
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_timer.sv
// tlc_dwell_timer: loadable down-counter with zero flag.
// The count parks at zero; the owner reloads it on every state entry.
module tlc_dwell_timer #(
    parameter int                TIMER_W = 8,
    parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_cnt;

    // Load wins over count-down; the count holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: rotates right-of-way over NUM_PHASES approaches
// (ALLRED -> GREEN -> YELLOW per phase) with latched pedestrian walk requests.
// Optional night flash mode is compiled in with TLC_NIGHT_FLASH_EN.
module traffic_intersection_ctrl
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int TIMER_W    = 8,
    parameter int GREEN_CYC  = 6,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int PED_CYC    = 10,
    parameter int FLASH_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    input  logic [NUM_PHASES-1:0]         i_ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic                          i_night_mode,
`endif
    output logic [NUM_PHASES-1:0]         o_red,
    output logic [NUM_PHASES-1:0]         o_yellow,
    output logic [NUM_PHASES-1:0]         o_green,
    output logic [NUM_PHASES-1:0]         o_ped_walk,
    output logic [$clog2(NUM_PHASES)-1:0] o_phase_idx,
    output logic [2:0]                    o_state
);

    localparam int PH_W    = $clog2(NUM_PHASES);
    localparam int WALK_CYC = (PED_CYC > GREEN_CYC) ? PED_CYC : GREEN_CYC;
    localparam logic [TIMER_W-1:0] LD_GREEN  = TIMER_W'(GREEN_CYC - 1);
    localparam logic [TIMER_W-1:0] LD_WALK   = TIMER_W'(WALK_CYC - 1);
    localparam logic [TIMER_W-1:0] LD_YELLOW = TIMER_W'(YELLOW_CYC - 1);
    localparam logic [TIMER_W-1:0] LD_ALLRED = TIMER_W'(ALLRED_CYC - 1);
`ifdef TLC_NIGHT_FLASH_EN
    localparam logic [TIMER_W-1:0] LD_FLASH  = TIMER_W'(FLASH_CYC - 1);
`endif

    if (!tlc_params_ok(NUM_PHASES, TIMER_W, GREEN_CYC, YELLOW_CYC, ALLRED_CYC,
                       PED_CYC, FLASH_CYC)) begin : g_bad_params
        $error("traffic_intersection_ctrl: parameter out of range");
    end

    tlc_state_e              r_state;
    logic [PH_W-1:0]         r_phase;
    logic [NUM_PHASES-1:0]   r_pend;
    logic [NUM_PHASES-1:0]   r_red, r_yellow, r_green, r_walk;

    logic                    w_tmr_zero;
    logic                    w_step;
    logic                    w_load;
    logic [TIMER_W-1:0]      w_load_val;
    logic [NUM_PHASES-1:0]   w_ph_mask;
    logic [NUM_PHASES-1:0]   w_pend_set;
    logic                    w_walk;

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_mask
        assign w_ph_mask[p] = lamp_sel(int'(r_phase), p);
    end

    // Requests arriving on the GREEN entry edge count for that green.
    assign w_pend_set = r_pend | i_ped_req;
    assign w_walk     = |(w_pend_set & w_ph_mask);
    assign w_step     = i_enable & w_tmr_zero;

    // Timer reload value for whichever state is entered on this edge.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LD_ALLRED;
        case (r_state)
            ALLRED: begin
                w_load = w_step;
`ifdef TLC_NIGHT_FLASH_EN
                if (i_night_mode)
                    w_load_val = LD_FLASH;
                else
`endif
                w_load_val = w_walk ? LD_WALK : LD_GREEN;
            end
            GREEN: begin
                w_load     = w_step;
                w_load_val = LD_YELLOW;
            end
            YELLOW: begin
                w_load     = w_step;
                w_load_val = LD_ALLRED;
            end
`ifdef TLC_NIGHT_FLASH_EN
            FLASH: begin
                w_load     = w_step;
                w_load_val = i_night_mode ? LD_FLASH : LD_ALLRED;
            end
`endif
            default: begin
                w_load     = 1'b1;
                w_load_val = LD_ALLRED;
            end
        endcase
    end

    tlc_dwell_timer #(
        .TIMER_W (TIMER_W),
        .RST_VAL (LD_ALLRED)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_enable),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_tmr_zero)
    );

    // FSM, phase rotation, pending requests and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ALLRED;
            r_phase  <= '0;
            r_pend   <= '0;
            r_red    <= '1;
            r_yellow <= '0;
            r_green  <= '0;
            r_walk   <= '0;
        end else begin
            r_pend <= w_pend_set;
            case (r_state)
                ALLRED: if (w_step) begin
`ifdef TLC_NIGHT_FLASH_EN
                    if (i_night_mode) begin
                        r_state  <= FLASH;
                        r_red    <= '0;
                        r_yellow <= '1;
                    end else
`endif
                    begin
                        r_state <= GREEN;
                        r_red   <= ~w_ph_mask;
                        r_green <= w_ph_mask;
                        r_walk  <= w_walk ? w_ph_mask : '0;
                        r_pend  <= w_pend_set & ~w_ph_mask;
                    end
                end
                GREEN: if (w_step) begin
                    r_state  <= YELLOW;
                    r_green  <= '0;
                    r_yellow <= w_ph_mask;
                    r_walk   <= '0;
                end
                YELLOW: if (w_step) begin
                    r_state  <= ALLRED;
                    r_phase  <= (r_phase == PH_W'(NUM_PHASES - 1)) ? '0 : r_phase + 1'b1;
                    r_yellow <= '0;
                    r_red    <= '1;
                end
`ifdef TLC_NIGHT_FLASH_EN
                FLASH: if (w_step) begin
                    if (!i_night_mode) begin
                        r_state  <= ALLRED;
                        r_phase  <= '0;
                        r_yellow <= '0;
                        r_red    <= '1;
                    end else begin
                        r_yellow <= ~r_yellow;
                    end
                end
`endif
                default: begin
                    r_state  <= ALLRED;
                    r_phase  <= '0;
                    r_red    <= '1;
                    r_yellow <= '0;
                    r_green  <= '0;
                    r_walk   <= '0;
                end
            endcase
        end
    end

    assign o_red       = r_red;
    assign o_yellow    = r_yellow;
    assign o_green     = r_green;
    assign o_ped_walk  = r_walk;
    assign o_phase_idx = r_phase;
    assign o_state     = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl (default build, night flash not compiled).
module tb_traffic_intersection_ctrl;

    localparam int N  = 4;
    localparam int G  = 6;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int PD = 10;
    localparam int GW = (PD > G) ? PD : G;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] red, yel, grn, walk;
    logic [1:0]   ph;
    logic [2:0]   st;

    int errs   = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    traffic_intersection_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (en),
        .i_ped_req   (req),
`ifdef TLC_NIGHT_FLASH_EN
        .i_night_mode(1'b0),
`endif
        .o_red       (red),
        .o_yellow    (yel),
        .o_green     (grn),
        .o_ped_walk  (walk),
        .o_phase_idx (ph),
        .o_state     (st)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: segment kind (0 allred, 1 green, 2 yellow), enabled cycles
    // spent in it, and its length in cycles.
    int           m_ph, m_seg, m_el, m_dur;
    bit           m_walk;
    logic [N-1:0] m_pend;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] pv;
        if (rst) begin
            m_ph = 0; m_seg = 0; m_el = 0; m_dur = AR; m_walk = 0; m_pend = '0;
        end else begin
            pv = m_pend | req;
            if (en) begin
                m_el++;
                if (m_el == m_dur) begin
                    m_el = 0;
                    if (m_seg == 0) begin
                        m_seg = 1; m_walk = pv[m_ph]; pv[m_ph] = 1'b0;
                        m_dur = m_walk ? GW : G;
                    end else if (m_seg == 1) begin
                        m_seg = 2; m_walk = 0; m_dur = Y;
                    end else begin
                        m_seg = 0; m_ph = (m_ph + 1) % N; m_dur = AR;
                    end
                end
            end
            m_pend = pv;
        end
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        logic [N-1:0] er, ey, eg, ew, oh;
        int bad;
        if (cmp_on) begin
            oh = '0; oh[m_ph] = 1'b1;
            eg = (m_seg == 1) ? oh : '0;
            ey = (m_seg == 2) ? oh : '0;
            ew = (m_seg == 1 && m_walk) ? oh : '0;
            er = ~(eg | ey);
            chk("lamps", {red, yel, grn, walk}, {er, ey, eg, ew});
            chk("phase_state", {ph, st}, {2'(m_ph), 3'(m_seg)});
            bad = 0;
            for (int p = 0; p < N; p++)
                if (int'(red[p]) + int'(yel[p]) + int'(grn[p]) != 1) bad++;
            chk("one_lamp_per_phase", bad, 0);
        end
    end

    task automatic wait_green(input int p);
        int g = 0;
        while (!grn[p] && g < 200) begin @(negedge clk); g++; end
        if (!grn[p]) chk("wait_green_timeout", 0, 1);
    endtask

    // Count green and walk cycles of the next green of phase p.
    task automatic measure_green(input int p, output int len, output int wl);
        int g = 0;
        len = 0; wl = 0;
        wait_green(p);
        while (grn[p] && g < 100) begin
            len++;
            if (walk[p]) wl++;
            @(negedge clk);
            g++;
        end
    endtask

    initial begin
        int len, wl;
        #1 rst = 1'b1;
        cmp_on = 1'b1;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic rotation with fixed expectations.
        chk("s1_reset_red", red, 4'hF);
        chk("s1_reset_state", {ph, st}, 5'd0);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            if (k == 1)  chk("s1_green0_first", grn, 4'h1);
            if (k == 6)  chk("s1_green0_last", grn, 4'h1);
            if (k == 7)  chk("s1_yellow0", yel, 4'h1);
            if (k == 9)  chk("s1_allred", red, 4'hF);
            if (k == 10) chk("s1_green1", grn, 4'h2);
            if (k == 36) chk("s1_allred_before_wrap", red, 4'hF);
            if (k == 37) chk("s1_green0_recur", grn, 4'h1);
        end

        // One-cycle request for phase 2 during green of phase 0.
        req[2] = 1'b1;
        @(negedge clk);
        req = '0;
        measure_green(2, len, wl);
        chk("s2_walk_green_len", len, 10);
        chk("s2_walk_len", wl, 10);
        measure_green(2, len, wl);
        chk("s2_next_green_len", len, 6);
        chk("s2_next_walk_len", wl, 0);

        // Freeze for 5 cycles from the 3rd green cycle of phase 1.
        wait_green(1);
        len = 1;
        for (int s = 2; s < 60; s++) begin
            @(negedge clk);
            if (!grn[1]) break;
            len++;
            if (s == 3) en = 1'b0;
            if (s == 8) en = 1'b1;
        end
        en = 1'b1;
        chk("s3_frozen_green_len", len, 11);

        // Reset mid-yellow of phase 3 with a pending request for phase 1.
        wait_green(3);
        req[1] = 1'b1;
        @(negedge clk);
        req = '0;
        while (!yel[3] && len < 500) begin @(negedge clk); len++; end
        #2 rst = 1'b1;
        #1;
        chk("s4_async_red", red, 4'hF);
        chk("s4_async_phase_state", {ph, st}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        measure_green(1, len, wl);
        chk("s4_pend_cleared_len", len, 6);
        chk("s4_pend_cleared_walk", wl, 0);

        // Request held during green of phase 0, after its entry.
        wait_green(0);
        req[0] = 1'b1;
        measure_green(0, len, wl);
        req = '0;
        chk("s5_held_green_len", len, 6);
        chk("s5_held_walk", wl, 0);
        measure_green(0, len, wl);
        chk("s5_next_green_len", len, 10);
        chk("s5_next_walk", wl, 10);

        // Randomized traffic, enable gaps and occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            en  = ($urandom_range(0, 9) != 0);
            req = '0;
            if ($urandom_range(0, 11) == 0) req[$urandom_range(0, N-1)] = 1'b1;
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
